// File: rtl/mac_round_sat.sv
// mac_round_sat: frame accumulator placed after the pipelined mult_signed core.
//
// The operand valid/last flags run through a MULT_LAT-deep delay line so that
// they line up with the product P. Each product is sign-extended to ACC_W bits
// and summed into a frame accumulator. A frame closes on a qualified last flag
// or on its MAX_LEN-th product. On close, the sum is registered three ways:
// full precision, rounded half-up, and saturated to Q1.15.
//
// Ports:
//   CLK       in   1      system clock, rising edge
//   SCLR      in   1      synchronous active-high clear, highest priority
//   IN_VLD    in   1      operand pair presented to the multiplier this cycle
//   IN_LAST   in   1      last operand pair of the frame (qualified by IN_VLD)
//   P         in   32     signed product, valid MULT_LAT cycles after IN_VLD
//   OUT_VLD   out  1      one-cycle result strobe
//   OUT_DATA  out  16     rounded/saturated Q1.15 frame sum
//   OUT_ACC   out  ACC_W  full-precision signed frame sum
//   OUT_SAT   out  1      OUT_DATA was clipped
//   OUT_OVF   out  1      frame was closed by MAX_LEN rather than IN_LAST
module mac_round_sat #(
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned MAX_LEN  = 256
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic             IN_VLD,
  input  logic             IN_LAST,
  input  logic [31:0]      P,
  output logic             OUT_VLD,
  output logic [15:0]      OUT_DATA,
  output logic [ACC_W-1:0] OUT_ACC,
  output logic             OUT_SAT,
  output logic             OUT_OVF
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  localparam logic signed [ACC_W-1:0] QMax   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] QMin   = -ACC_W'(32768);
  localparam logic signed [ACC_W-1:0] RndAdd = ACC_W'(1 << 14);

  // Flag delay lines, aligned with the multiplier pipeline
  logic [MULT_LAT-1:0] r_vld_sr;
  logic [MULT_LAT-1:0] r_last_sr;

  logic [ACC_W-1:0] r_acc;
  // cnt == 0 marks an empty frame
  logic [CNT_W-1:0] r_cnt;

  logic             r_out_vld;
  logic [15:0]      r_out_data;
  logic [ACC_W-1:0] r_out_acc;
  logic             r_out_sat;
  logic             r_out_ovf;

  logic                    w_vld_d;
  logic                    w_last_d;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_close;
  logic signed [ACC_W-1:0] w_rnd;
  logic [15:0]             w_data;
  logic                    w_sat;

  assign w_vld_d  = r_vld_sr[MULT_LAT-1];
  // A last flag without a valid flag carries no meaning
  assign w_last_d = r_last_sr[MULT_LAT-1] & w_vld_d;

  always_comb begin
    w_sext     = ACC_W'($signed(P));
    w_acc_next = (r_cnt == '0) ? w_sext : $signed(r_acc) + w_sext;
    w_cnt_inc  = r_cnt + CNT_W'(1);
    w_close    = w_vld_d & (w_last_d | (w_cnt_inc == CNT_W'(MAX_LEN)));

    // Round half-up in Q1.15. Adding 2^14 before the arithmetic shift does this.
    w_rnd = (w_acc_next + RndAdd) >>> 15;
    w_sat = 1'b0;
    if (w_rnd > QMax) begin
      w_data = 16'h7FFF;
      w_sat  = 1'b1;
    end else if (w_rnd < QMin) begin
      w_data = 16'h8000;
      w_sat  = 1'b1;
    end else begin
      w_data = w_rnd[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      r_vld_sr   <= '0;
      r_last_sr  <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_acc  <= '0;
      r_out_sat  <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else begin
      r_vld_sr[0]  <= IN_VLD;
      r_last_sr[0] <= IN_LAST & IN_VLD;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end

      r_out_vld <= w_close;

      if (w_vld_d) begin
        r_acc <= w_acc_next;
        // On close the count returns to zero, so the next product starts a new
        // frame with no idle cycle in between.
        r_cnt <= w_close ? '0 : w_cnt_inc;
      end

      if (w_close) begin
        r_out_data <= w_data;
        r_out_acc  <= w_acc_next;
        r_out_sat  <= w_sat;
        r_out_ovf  <= ~w_last_d;
      end
    end
  end

  assign OUT_VLD  = r_out_vld;
  assign OUT_DATA = r_out_data;
  assign OUT_ACC  = r_out_acc;
  assign OUT_SAT  = r_out_sat;
  assign OUT_OVF  = r_out_ovf;

endmodule

// File: doc/mac_round_sat.md
Name: mac_round_sat

Overview:
- Downstream consumer of the pipelined mult_signed core (16x16 signed, 32-bit P).
- Tracks operand-valid/last flags alongside the multiplier pipeline and aligns them with P.
- Accumulates one frame of Q1.15 x Q1.15 products (Q2.30) in a wide accumulator, then emits a rounded, saturated Q1.15 result plus the raw accumulator.
- Sits between the multiplier and the FIR/correlation result path.

Parameters:
- MULT_LAT, 3: cycles from A/B valid at the multiplier input to P valid. Legal range 1..8; must match the mult_signed IP configuration.
- ACC_W, 40: accumulator width. Must be >= 32.
- MAX_LEN, 256: maximum products per frame. The frame auto-closes on the MAX_LEN-th product.

Ports:
- CLK  in  1  system clock; all logic on rising edge
- SCLR  in  1  reset, synchronous, active-high
- IN_VLD  in  1  A/B presented to mult_signed this cycle
- IN_LAST  in  1  qualifies IN_VLD; last operand pair of frame
- P  in  32  signed product from mult_signed, valid MULT_LAT cycles after IN_VLD
- OUT_VLD  out  1  one-cycle pulse, result valid
- OUT_DATA  out  16  rounded/saturated Q1.15 frame sum
- OUT_ACC  out  ACC_W  full-precision frame sum, signed
- OUT_SAT  out  1  OUT_DATA was clipped
- OUT_OVF  out  1  frame closed by MAX_LEN, not by IN_LAST

Behaviour:
- Reset: SCLR=1 at a clock edge clears everything: delay lines, accumulator, counter and all outputs, which go to 0. This applies mid-frame too: in-flight products are discarded, no OUT_VLD is produced for them, and the next accepted product starts a new frame. SCLR has priority over all other inputs.
- Alignment: IN_VLD and IN_LAST pass through a MULT_LAT-stage shift register, giving vld_d and last_d, which are coincident with the corresponding P. IN_LAST is ignored when IN_VLD=0. P is ignored when vld_d=0.
- Accumulation:
  - sext(P) is P sign-extended to ACC_W.
  - On vld_d=1: acc_next = sext(P) if the frame is empty, else acc + sext(P).
  - cnt increments on each accepted product.
  - Back-to-back frames run at full rate, with no bubble: the product following a close starts a fresh frame in the same cycle the previous result is registered.
  - Accumulator overflow is not possible within spec (ACC_W=40, MAX_LEN<=256); the implementation does not detect it.
- Frame close: on vld_d=1 and (last_d=1 or cnt+1==MAX_LEN):
  - Register the outputs from acc_next. OUT_VLD=1 on the next cycle, for exactly one cycle.
  - OUT_OVF=1 iff last_d=0 at close.
  - Reset the frame to empty.
  - Gaps (vld_d=0) inside a frame are allowed and hold acc and cnt.
- Rounding/saturation, computed on the ACC_W-bit value S:
  - R = (S + 2^14) >>> 15, arithmetic shift: round-half-up in Q1.15.
  - If R > 32767: OUT_DATA=16'h7FFF, OUT_SAT=1.
  - If R < -32768: OUT_DATA=16'h8000, OUT_SAT=1.
  - Otherwise OUT_DATA=R[15:0], OUT_SAT=0.
- Output hold: OUT_DATA/OUT_ACC/OUT_SAT/OUT_OVF hold their values until the next OUT_VLD.
- Latency: OUT_VLD is asserted MULT_LAT+1 cycles after the cycle carrying IN_VLD&IN_LAST.
- No backpressure: the downstream stage must accept OUT_VLD unconditionally.

Test Plan:
- Single-product frames, MULT_LAT=3, three back-to-back cycles with IN_VLD=1, IN_LAST=1:
  - A=8003,B=FFFF -> OUT_ACC=32765, OUT_DATA=0001, SAT=0.
  - A=8000,B=8000 -> OUT_ACC=0x40000000, OUT_DATA=7FFF, SAT=1.
  - A=8009,B=000A -> OUT_ACC=-327590, OUT_DATA=FFF6, SAT=0.
  - Expect three consecutive OUT_VLD pulses starting 4 cycles after the first input.
- Four-product frame, A=4000,B=4000 each (P=0x10000000), IN_LAST on the 4th -> OUT_ACC=0x40000000, OUT_DATA=7FFF, SAT=1. Then a frame of A=C000,B=4000 x2 -> OUT_ACC=-0x20000000, OUT_DATA=C000, SAT=0.
- Rounding boundary: P=0x00004000 (A=0001,B=4000) single frame -> OUT_DATA=0001. P=-0x4001 (A=FFFF,B=4001) -> OUT_DATA=FFFF. P=0x3FFF (A=0001,B=3FFF) -> OUT_DATA=0000.
- MAX_LEN=4, six valid products of A=0100,B=0100 with no IN_LAST -> OUT_VLD after the 4th product with OUT_ACC=0x40000, OUT_DATA=0008, OVF=1. IN_LAST on the 6th -> second result OUT_ACC=0x20000, OUT_DATA=0004, OVF=0.
- Gapped frame: products 0x8000 (A=0001,B=8000... sign-correct values) interleaved with IN_VLD=0 cycles -> sum equals the gapless sum, and OUT_VLD timing follows the last product only.
- SCLR pulse mid-frame after 2 of 4 products -> no OUT_VLD for that frame, and all outputs read 0 the cycle after SCLR. A following 1-product frame A=0002,B=4000 yields OUT_DATA=0001 with no residue.
